pipeline_hazard_sequencer: RTL and testbench
============================================

// Module: pipeline_hazard_sequencer
// PURPOSE
//  Sequences the 5-stage pipeline datapath (IF/ID/EX/MEM/WB) that has no forwarding and no condition logic.
//  - Start/idle control.
//  - Register-pending scoreboard: stalls decode on RAW hazards and injects EX bubbles.
//  - Branch freeze until the branch resolves in WB.
//  - Owns the NZCV flags register and the WB-stage condition check that gates RegWrite/PCSrc.
// PARAMETERS
//  NREG    16  architectural registers; scoreboard tag width = clog2(NREG)
//  BR_LAT  3   cycles from branch leaving ID to branch in WB
// PORTS
//  clk            in   1  clock; all state on rising edge
//  reset          in   1  synchronous, active-high
//  start          in   1  1-cycle pulse; leaves IDLE
//  ra1_d, ra2_d   in   4  ID source register numbers (after RegSrc muxing)
//  use_ra1_d      in   1  ID instruction reads ra1_d
//  use_ra2_d      in   1  ID instruction reads ra2_d
//  wa3_d          in   4  ID destination (InstrD[15:12])
//  regwrite_d     in   1  ID instruction writes register file
//  branch_d       in   1  ID instruction is a branch / writes PC
//  cond_w         in   4  WB condition field
//  alu_flags_w    in   4  WB ALU flags {N,Z,C,V}
//  flagswrite_w   in   1  WB instruction updates flags
//  regwrite_w     in   1  WB raw RegWrite
//  branch_w       in   1  WB raw Branch
//  run            out  1  1 when not IDLE
//  stall_f        out  1  hold PC
//  stall_d        out  1  hold IF/ID
//  flush_d        out  1  IF/ID loads NOP on next edge
//  flush_e        out  1  ID/EX loads bubble (all controls 0) on next edge
//  regwrite_w_g   out  1  gated register-file write enable
//  pc_src_w       out  1  PC mux select (Result)
//  flags_q        out  4  current NZCV
// BEHAVIOUR
//  Reset values:
//  - State = IDLE; scoreboard cleared; flags_q = 0; d_valid = 0.
//  - stall_f = stall_d = 1; flush_d = flush_e = 1; run = 0; regwrite_w_g = pc_src_w = 0.
//  IDLE:
//  - Outputs held at their reset values.
//  - start = 1 -> RUN; d_valid = 0 on entry.
//  - start is ignored in RUN and BR_WAIT.
//  Scoreboard:
//  - 3 entries {valid, tag} for E, M, W; shifts every cycle in RUN and BR_WAIT.
//  - New E entry = {regwrite_d & d_valid & ~hazard, wa3_d}.
//  - A bubble enters E as invalid.
//  - Register-file writes do not bypass, so the W entry still blocks readers.
//  RAW hazard (RUN only):
//  - hazard = d_valid & ((use_ra1_d & ra1_d matches any valid entry) | (use_ra2_d & ra2_d matches any valid entry)).
//  - Response: stall_f = stall_d = 1, flush_e = 1, flush_d = 0.
//  - Worst-case stall is 3 cycles.
//  - A hazard on the WB-stage entry clears in the cycle after that instruction leaves WB.
//  - Condition-failed writers still stall (conservative).
//  Branch, with branch_d & d_valid & ~hazard at cycle t:
//  - t: flush_d = 1, stall_f = 1; -> BR_WAIT with counter = BR_LAT-1.
//  - t+1 .. t+BR_LAT-1: stall_f = 1, flush_d = 1.
//  - t+BR_LAT (branch in WB): stall_f = 0.
//    - Taken (pc_src_w = 1): flush_d = 1.
//    - Not taken: flush_d = 0, and the held PC (branch+4) proceeds.
//  - -> RUN.
//  - hazard takes priority over branch: the branch waits in ID.
//  - No new branch can appear in ID during BR_WAIT.
//  d_valid:
//  - Set on every IF/ID load in RUN or BR_WAIT.
//  - Cleared by flush_d, reset, or IDLE.
//  - Held during stall_d.
//  Condition check (combinational on cond_w, flags_q):
//  - Codes 0000 EQ through 1101 LE follow the standard ARM equations.
//  - 1110 AL = 1; 1111 = 0.
//  - regwrite_w_g = regwrite_w & cond_ok.
//  - pc_src_w = branch_w & cond_ok.
//  - flags_q <= alu_flags_w when flagswrite_w & cond_ok, registered with 1-cycle latency, in RUN/BR_WAIT only.
//  Reset mid-operation:
//  - Returns to IDLE next edge; scoreboard, flags and counter are cleared.
//  - In-flight stages are the datapath's responsibility.
// TESTING
//  T1:
//  - Stimulus: reset 2 cycles, then start pulse.
//  - Response: run=1 next cycle; stall_f=0; flags_q=0; no flush.
//  T2:
//  - Stimulus: ADD r1 in ID, then next instr reads r1 (use_ra1_d, ra1_d=1).
//  - Response: stall_f=stall_d=flush_e=1 for exactly 3 cycles, then released.
//  T3:
//  - Stimulus: taken branch (cond AL) accepted at cycle t.
//  - Response: stall_f=1 for t..t+2; flush_d=1 for t..t+3; pc_src_w=1 at t+3; state RUN at t+4.
//  T4:
//  - Stimulus: BEQ with flags_q Z=0.
//  - Response: pc_src_w=0 at t+3; flush_d=0 at t+3; fetch resumes at branch+4.
//  T5:
//  - Stimulus: CMP in WB with flagswrite_w=1, alu_flags_w=4'b0100; then cond_w=0000 with regwrite_w=1.
//  - Response: flags_q=0100; regwrite_w_g=1.
//  - Stimulus: same, with cond_w=0001.
//  - Response: regwrite_w_g=0.
//  T6:
//  - Stimulus: reset asserted mid-BR_WAIT.
//  - Response: IDLE next edge; stall_f=1; flags_q=0.
//  - Stimulus: start pulse.
//  - Response: clean restart with empty scoreboard.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard/branch sequencer for a 5-stage pipeline with no forwarding: RAW scoreboard,
// branch freeze until WB, and the NZCV flags register with the WB condition check.
module pipeline_hazard_sequencer #(
  parameter int NREG   = 16,
  parameter int BR_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(NREG)-1:0]  ra1_d,
  input  logic [$clog2(NREG)-1:0]  ra2_d,
  input  logic                     use_ra1_d,
  input  logic                     use_ra2_d,
  input  logic [$clog2(NREG)-1:0]  wa3_d,
  input  logic                     regwrite_d,
  input  logic                     branch_d,
  input  logic [3:0]               cond_w,
  input  logic [3:0]               alu_flags_w,
  input  logic                     flagswrite_w,
  input  logic                     regwrite_w,
  input  logic                     branch_w,
  output logic                     run,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic                     regwrite_w_g,
  output logic                     pc_src_w,
  output logic [3:0]               flags_q
);

  localparam int TW = $clog2(NREG);
  localparam int CW = (BR_LAT > 1) ? $clog2(BR_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, BR_WAIT} state_t;

  state_t          state_reg;
  logic [CW-1:0]   br_cnt_reg;
  logic            d_valid_reg;
  logic            d_valid_next;
  logic [2:0]      sb_valid_reg;          // index 0 = EX, 1 = MEM, 2 = WB
  logic [TW-1:0]   sb_tag_reg [3];
  logic [3:0]      flags_reg;

  logic [2:0]      hit1;
  logic [2:0]      hit2;
  logic            active;
  logic            hazard;
  logic            branch_go;
  logic            cond_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_match
      assign hit1[gi] = sb_valid_reg[gi] && (sb_tag_reg[gi] == ra1_d);
      assign hit2[gi] = sb_valid_reg[gi] && (sb_tag_reg[gi] == ra2_d);
    end
  endgenerate

  assign active    = (state_reg != IDLE);
  assign hazard    = (state_reg == RUN) && d_valid_reg &&
                     ((use_ra1_d && |hit1) || (use_ra2_d && |hit2));
  assign branch_go = (state_reg == RUN) && branch_d && d_valid_reg && !hazard;

  // flags_reg = {N, Z, C, V}
  always_comb begin
    cond_ok = 1'b0;
    case (cond_w)
      4'h0: cond_ok = flags_reg[2];
      4'h1: cond_ok = !flags_reg[2];
      4'h2: cond_ok = flags_reg[1];
      4'h3: cond_ok = !flags_reg[1];
      4'h4: cond_ok = flags_reg[3];
      4'h5: cond_ok = !flags_reg[3];
      4'h6: cond_ok = flags_reg[0];
      4'h7: cond_ok = !flags_reg[0];
      4'h8: cond_ok = flags_reg[1] && !flags_reg[2];
      4'h9: cond_ok = !flags_reg[1] || flags_reg[2];
      4'ha: cond_ok = (flags_reg[3] == flags_reg[0]);
      4'hb: cond_ok = (flags_reg[3] != flags_reg[0]);
      4'hc: cond_ok = !flags_reg[2] && (flags_reg[3] == flags_reg[0]);
      4'hd: cond_ok = flags_reg[2] || (flags_reg[3] != flags_reg[0]);
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign regwrite_w_g = active && regwrite_w && cond_ok;
  assign pc_src_w     = active && branch_w && cond_ok;
  assign run          = active;
  assign flags_q      = flags_reg;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    case (state_reg)
      RUN: begin
        if (hazard) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (branch_go) begin
          stall_f = 1'b1;
          flush_d = 1'b1;
        end
      end
      BR_WAIT: begin
        if (br_cnt_reg != '0) begin
          stall_f = 1'b1;
          flush_d = 1'b1;
        end else begin
          // branch is in WB: a not-taken branch lets the held branch+4 through
          flush_d = pc_src_w;
        end
      end
      default: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    endcase
  end

  always_comb begin
    d_valid_next = d_valid_reg;
    if (!active || flush_d)
      d_valid_next = 1'b0;
    else if (!stall_d)
      d_valid_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      br_cnt_reg   <= '0;
      d_valid_reg  <= 1'b0;
      sb_valid_reg <= '0;
      for (int i = 0; i < 3; i++) sb_tag_reg[i] <= '0;
      flags_reg    <= '0;
    end else begin
      d_valid_reg <= d_valid_next;
      case (state_reg)
        IDLE: if (start) state_reg <= RUN;
        RUN: begin
          if (branch_go) begin
            state_reg  <= BR_WAIT;
            br_cnt_reg <= CW'(BR_LAT - 1);
          end
        end
        BR_WAIT: begin
          if (br_cnt_reg != '0)
            br_cnt_reg <= br_cnt_reg - CW'(1);
          else
            state_reg <= RUN;
        end
        default: state_reg <= IDLE;
      endcase
      if (active) begin
        sb_valid_reg  <= {sb_valid_reg[1:0], regwrite_d && d_valid_reg && !hazard};
        sb_tag_reg[0] <= wa3_d;
        sb_tag_reg[1] <= sb_tag_reg[0];
        sb_tag_reg[2] <= sb_tag_reg[1];
        if (flagswrite_w && cond_ok)
          flags_reg <= alu_flags_w;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer: start, RAW stalls, taken/not-taken
// branches, condition table, flag update and reset during a branch freeze.
module tb_pipeline_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] ra1_d, ra2_d, wa3_d, cond_w, alu_flags_w;
  logic       use_ra1_d, use_ra2_d, regwrite_d, branch_d;
  logic       flagswrite_w, regwrite_w, branch_w;
  logic       run, stall_f, stall_d, flush_d, flush_e, regwrite_w_g, pc_src_w;
  logic [3:0] flags_q;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_sequencer #(.NREG(16), .BR_LAT(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .use_ra1_d(use_ra1_d), .use_ra2_d(use_ra2_d),
    .wa3_d(wa3_d), .regwrite_d(regwrite_d), .branch_d(branch_d),
    .cond_w(cond_w), .alu_flags_w(alu_flags_w), .flagswrite_w(flagswrite_w),
    .regwrite_w(regwrite_w), .branch_w(branch_w),
    .run(run), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .regwrite_w_g(regwrite_w_g), .pc_src_w(pc_src_w),
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; ra1_d = 0; ra2_d = 0; use_ra1_d = 0; use_ra2_d = 0; wa3_d = 0;
    regwrite_d = 0; branch_d = 0; cond_w = 4'he; alu_flags_w = 0;
    flagswrite_w = 0; regwrite_w = 0; branch_w = 0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flagswrite_w = 1; alu_flags_w = f; cond_w = 4'he;
    tick();
    flagswrite_w = 0;
  endtask

  logic [15:0] cond_exp;

  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    // T1: reset state, outputs gated even with WB requests present
    regwrite_w = 1; branch_w = 1; #1;
    check("rst_run", run, 0);
    check("rst_stall_f", stall_f, 1);
    check("rst_stall_d", stall_d, 1);
    check("rst_flush_d", flush_d, 1);
    check("rst_flush_e", flush_e, 1);
    check("rst_flags", flags_q, 0);
    check("rst_rw_g", regwrite_w_g, 0);
    check("rst_pcsrc", pc_src_w, 0);
    regwrite_w = 0; branch_w = 0;
    reset = 0; start = 1;
    tick();
    start = 0; #1;
    check("t1_run", run, 1);
    check("t1_stall_f", stall_f, 0);
    check("t1_flush_d", flush_d, 0);
    check("t1_flush_e", flush_e, 0);
    check("t1_flags", flags_q, 0);

    // T2: ADD r1 then reader of r1 -> exactly 3 stall cycles
    tick();
    regwrite_d = 1; wa3_d = 1; #1;
    check("t2_add_nostall", stall_f, 0);
    tick();
    regwrite_d = 0; use_ra1_d = 1; ra1_d = 1; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_stall_f_%0d", i), stall_f, 1);
      check($sformatf("t2_stall_d_%0d", i), stall_d, 1);
      check($sformatf("t2_flush_e_%0d", i), flush_e, 1);
      check($sformatf("t2_flush_d_%0d", i), flush_d, 0);
      tick(); #1;
    end
    check("t2_release_f", stall_f, 0);
    check("t2_release_e", flush_e, 0);

    // ra2 hazard against WB-stage entry only; unused source ignored
    tick();
    use_ra1_d = 0; regwrite_d = 1; wa3_d = 5; #1;
    tick();
    regwrite_d = 0; #1;
    tick();
    ra2_d = 5; use_ra2_d = 0; #1;
    check("ra2_unused", stall_f, 0);
    tick();
    use_ra2_d = 1; #1;
    check("ra2_wb_hazard", stall_f, 1);
    tick(); #1;
    check("ra2_wb_clear", stall_f, 0);

    // T3: taken branch (AL)
    tick();
    use_ra2_d = 0; branch_d = 1; #1;
    check("t3_t_flush_d", flush_d, 1);
    check("t3_t_stall_f", stall_f, 1);
    check("t3_t_flush_e", flush_e, 0);
    tick();
    branch_d = 0; #1;
    check("t3_t1_stall_f", stall_f, 1);
    check("t3_t1_flush_d", flush_d, 1);
    tick(); #1;
    check("t3_t2_stall_f", stall_f, 1);
    check("t3_t2_flush_d", flush_d, 1);
    tick();
    branch_w = 1; cond_w = 4'he; #1;
    check("t3_t3_pcsrc", pc_src_w, 1);
    check("t3_t3_stall_f", stall_f, 0);
    check("t3_t3_flush_d", flush_d, 1);
    tick();
    branch_w = 0; #1;
    check("t3_t4_run", run, 1);
    check("t3_t4_flush_d", flush_d, 0);
    check("t3_t4_stall_f", stall_f, 0);

    // T4: BEQ with Z=0 -> not taken
    tick();
    branch_d = 1; #1;
    check("t4_t_flush_d", flush_d, 1);
    tick();
    branch_d = 0;
    tick();
    tick();
    branch_w = 1; cond_w = 4'h0; #1;
    check("t4_t3_pcsrc", pc_src_w, 0);
    check("t4_t3_flush_d", flush_d, 0);
    check("t4_t3_stall_f", stall_f, 0);
    tick();
    branch_w = 0; #1;
    check("t4_t4_stall_f", stall_f, 0);

    // T5: flag write latency, EQ/NE gating, full condition table
    flagswrite_w = 1; alu_flags_w = 4'b0100; cond_w = 4'he; #1;
    check("t5_flags_latency", flags_q, 4'b0000);
    tick();
    flagswrite_w = 0; cond_w = 4'h0; regwrite_w = 1; #1;
    check("t5_flags", flags_q, 4'b0100);
    check("t5_eq_rw_g", regwrite_w_g, 1);
    cond_w = 4'h1; #1;
    check("t5_ne_rw_g", regwrite_w_g, 0);
    cond_exp = 16'h66a9;
    for (int c = 0; c < 16; c++) begin
      cond_w = 4'(c); #1;
      check($sformatf("cond0100_%0h", c), regwrite_w_g, cond_exp[c]);
    end
    regwrite_w = 0;
    set_flags(4'b1011);
    check("flags_1011", flags_q, 4'b1011);
    regwrite_w = 1;
    cond_exp = 16'h5556;
    for (int c = 0; c < 16; c++) begin
      cond_w = 4'(c); #1;
      check($sformatf("cond1011_%0h", c), regwrite_w_g, cond_exp[c]);
    end
    regwrite_w = 0;
    cond_w = 4'h0; flagswrite_w = 1; alu_flags_w = 4'b0000;
    tick();
    flagswrite_w = 0; cond_w = 4'he; #1;
    check("flags_condfail_hold", flags_q, 4'b1011);

    // T6: reset mid-BR_WAIT with a live scoreboard entry for r7
    regwrite_d = 1; wa3_d = 7; #1;
    check("t6_writer", stall_f, 0);
    tick();
    regwrite_d = 0; branch_d = 1; #1;
    check("t6_branch", flush_d, 1);
    tick();
    branch_d = 0; #1;
    check("t6_brwait_stall", stall_f, 1);
    reset = 1;
    tick(); #1;
    check("t6_idle_run", run, 0);
    check("t6_idle_stall_f", stall_f, 1);
    check("t6_idle_flags", flags_q, 0);
    reset = 0; start = 1;
    tick();
    start = 0; #1;
    check("t6_restart_run", run, 1);
    check("t6_restart_stall", stall_f, 0);
    tick();
    use_ra1_d = 1; ra1_d = 7; #1;
    check("t6_sb_empty", stall_f, 0);
    tick();
    use_ra1_d = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
